// File: rtl/uart_alu_requester.sv
// Host-side initiator for the UART ALU protocol: sends A, B, op as three
// UART bytes, then parses the result/flags/status reply with a byte timeout.
module uart_alu_requester #(
    parameter int                   DATA_BITS      = 8,
    parameter logic [DATA_BITS-1:0] OK_STATUS      = 8'h55,
    parameter int                   TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DATA_BITS-1:0] req_a,
    input  logic [DATA_BITS-1:0] req_b,
    input  logic [5:0]           req_op,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_done,
    input  logic                 rx_done,
    input  logic [DATA_BITS-1:0] rx_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_result,
    output logic                 resp_zero,
    output logic                 resp_overflow,
    output logic                 resp_carry,
    output logic                 resp_err_status,
    output logic                 resp_err_timeout,
    output logic                 busy
);
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] SEND_A   = 4'd1;
    localparam logic [3:0] WAIT_A   = 4'd2;
    localparam logic [3:0] SEND_B   = 4'd3;
    localparam logic [3:0] WAIT_B   = 4'd4;
    localparam logic [3:0] SEND_OP  = 4'd5;
    localparam logic [3:0] WAIT_OP  = 4'd6;
    localparam logic [3:0] RECV_RES = 4'd7;
    localparam logic [3:0] RECV_FLG = 4'd8;
    localparam logic [3:0] RECV_STA = 4'd9;
    localparam logic [3:0] RESP     = 4'd10;

    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [3:0]           state;
    logic [DATA_BITS-1:0] b_q;
    logic [5:0]           op_q;
    logic [4:0]           flg_low;
    logic [CW-1:0]        cnt;
    logic                 expired;

    // Counter reaches TIMEOUT_CYCLES-1 on the edge that takes it past CNT_LAST
    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            tx_start         <= 1'b0;
            tx_data          <= '0;
            resp_valid       <= 1'b0;
            resp_result      <= '0;
            resp_zero        <= 1'b0;
            resp_overflow    <= 1'b0;
            resp_carry       <= 1'b0;
            resp_err_status  <= 1'b0;
            resp_err_timeout <= 1'b0;
            busy             <= 1'b0;
            b_q              <= '0;
            op_q             <= '0;
            flg_low          <= '0;
            cnt              <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        b_q              <= req_b;
                        op_q             <= req_op;
                        tx_data          <= req_a;
                        tx_start         <= 1'b1;
                        req_ready        <= 1'b0;
                        busy             <= 1'b1;
                        resp_result      <= '0;
                        resp_zero        <= 1'b0;
                        resp_overflow    <= 1'b0;
                        resp_carry       <= 1'b0;
                        resp_err_status  <= 1'b0;
                        resp_err_timeout <= 1'b0;
                        flg_low          <= '0;
                        cnt              <= '0;
                        state            <= SEND_A;
                    end
                end
                SEND_A:  state <= WAIT_A;
                SEND_B:  state <= WAIT_B;
                SEND_OP: state <= WAIT_OP;
                WAIT_A: begin
                    if (tx_done) begin
                        tx_start <= 1'b1;
                        tx_data  <= b_q;
                        state    <= SEND_B;
                    end
                end
                WAIT_B: begin
                    if (tx_done) begin
                        tx_start <= 1'b1;
                        tx_data  <= {{(DATA_BITS-6){1'b0}}, op_q};
                        state    <= SEND_OP;
                    end
                end
                WAIT_OP: begin
                    if (tx_done) begin
                        cnt   <= '0;
                        state <= RECV_RES;
                    end
                end
                RECV_RES: begin
                    if (rx_done) begin
                        resp_result <= rx_data;
                        cnt         <= '0;
                        state       <= RECV_FLG;
                    end else if (expired) begin
                        resp_err_timeout <= 1'b1;
                        resp_valid       <= 1'b1;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RECV_FLG: begin
                    if (rx_done) begin
                        resp_zero     <= rx_data[7];
                        resp_overflow <= rx_data[6];
                        resp_carry    <= rx_data[5];
                        flg_low       <= rx_data[4:0];
                        cnt           <= '0;
                        state         <= RECV_STA;
                    end else if (expired) begin
                        resp_err_timeout <= 1'b1;
                        resp_valid       <= 1'b1;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RECV_STA: begin
                    if (rx_done) begin
                        resp_err_status <= (rx_data != OK_STATUS) ||
                                           (flg_low != 5'd0);
                        cnt             <= '0;
                        resp_valid      <= 1'b1;
                        state           <= RESP;
                    end else if (expired) begin
                        resp_err_timeout <= 1'b1;
                        resp_valid       <= 1'b1;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_alu_requester.sv
// Scoreboard bench for uart_alu_requester: models the UART TX/RX byte
// handshakes and checks transmitted bytes and decoded responses.
module tb_uart_alu_requester;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic [5:0] req_op = '0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] resp_result;
    logic       resp_zero;
    logic       resp_overflow;
    logic       resp_carry;
    logic       resp_err_status;
    logic       resp_err_timeout;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  tx_q[$];
    logic [12:0] resp_q[$];

    uart_alu_requester #(
        .DATA_BITS(8),
        .OK_STATUS(8'h55),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .rx_done(rx_done),
        .rx_data(rx_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_result(resp_result),
        .resp_zero(resp_zero),
        .resp_overflow(resp_overflow),
        .resp_carry(resp_carry),
        .resp_err_status(resp_err_status),
        .resp_err_timeout(resp_err_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] actual();
        return {resp_result, resp_zero, resp_overflow, resp_carry,
                resp_err_status, resp_err_timeout};
    endfunction

    // Expected {result, z, o, c, err_status, err_timeout} after n reply bytes
    function automatic logic [12:0] model(input logic [7:0] r,
                                          input logic [7:0] f,
                                          input logic [7:0] s,
                                          input int n);
        logic [12:0] e;
        e = '0;
        if (n >= 1) e[12:5] = r;
        if (n >= 2) e[4:2] = f[7:5];
        if (n >= 3) e[1] = (s != 8'h55) || (f[4:0] != 5'd0);
        else        e[0] = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if ({req_ready, tx_start, resp_valid, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL %s: rdy/start/valid/busy got %b want 1000",
                     name, {req_ready, tx_start, resp_valid, busy});
        end
    endtask

    task automatic send_req(input logic [7:0] a, input logic [7:0] b,
                            input logic [5:0] op);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_wait: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_op = op;
        tick();
        req_valid = 1'b0;
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        req_op = 6'($urandom);
    endtask

    task automatic serve_byte(input bit done, input bit inject);
        int n = 0;
        logic [7:0] exp;
        while (tx_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
        vectors++;
        if (tx_start !== 1'b1 || tx_data !== exp) begin
            miscompares++;
            $display("FAIL tx_byte: got start=%b data=%h want start=1 data=%h",
                     tx_start, tx_data, exp);
        end
        tick();
        vectors++;
        if (tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_pulse: got start=%b want 0", tx_start);
        end
        if (done) begin
            if (inject) begin
                rx_data = 8'($urandom);
                rx_done = 1'b1;
            end
            tick();
            rx_done = 1'b0;
            vectors++;
            if (tx_start !== 1'b0 || tx_data !== exp) begin
                miscompares++;
                $display("FAIL tx_hold: got start=%b data=%h want 0 %h",
                         tx_start, tx_data, exp);
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    task automatic send_rx(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        tick();
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (resp_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: resp_valid never rose (got %b want 1)",
                     name, resp_valid);
        end
    endtask

    task automatic check_resp(input string name);
        logic [12:0] exp;
        wait_valid(name);
        exp = (resp_q.size() > 0) ? resp_q.pop_front() : 13'h0;
        vectors++;
        if (actual() !== exp) begin
            miscompares++;
            $display("FAIL %s: resp got %h want %h", name, actual(), exp);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_idle({name, "_ack"});
    endtask

    task automatic push_txn(input logic [7:0] a, input logic [7:0] b,
                            input logic [5:0] op);
        tx_q.push_back(a);
        tx_q.push_back(b);
        tx_q.push_back({2'b00, op});
    endtask

    task automatic run_txn(input string name, input logic [7:0] a,
                           input logic [7:0] b, input logic [5:0] op,
                           input logic [7:0] r, input logic [7:0] f,
                           input logic [7:0] s, input bit inject);
        push_txn(a, b, op);
        resp_q.push_back(model(r, f, s, 3));
        send_req(a, b, op);
        for (int i = 0; i < 3; i++) serve_byte(1'b1, inject);
        send_rx(r);
        send_rx(f);
        send_rx(s);
        check_resp(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        check_idle("reset_ctrl");
        vectors++;
        if ({tx_data, actual()} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {tx_data, actual()});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        run_txn("add", 8'h05, 8'h03, 6'h20, 8'h08, 8'h00, 8'h55, 1'b0);
    endtask

    task automatic test_flags();
        run_txn("flags_ok", 8'h80, 8'h80, 6'h20, 8'h00, 8'hE0, 8'h55, 1'b0);
        run_txn("flags_rsv", 8'h80, 8'h80, 6'h20, 8'h00, 8'hE1, 8'h55, 1'b0);
        run_txn("flags_c", 8'hFF, 8'h01, 6'h20, 8'h00, 8'h20, 8'h55, 1'b0);
    endtask

    task automatic test_bad_status();
        run_txn("bad_status", 8'h1E, 8'h1E, 6'h21, 8'h3C, 8'h00, 8'hAA, 1'b0);
    endtask

    task automatic test_timeout();
        int n = 0;
        push_txn(8'h10, 8'h01, 6'h20);
        resp_q.push_back(model(8'h11, 8'h00, 8'h00, 1));
        send_req(8'h10, 8'h01, 6'h20);
        for (int i = 0; i < 3; i++) serve_byte(1'b1, 1'b0);
        rx_data = 8'h11;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        while (resp_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 99) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d cycles want 99", n);
        end
        check_resp("timeout");
    endtask

    task automatic test_timeout_edge();
        push_txn(8'h10, 8'h01, 6'h20);
        resp_q.push_back(model(8'h11, 8'hE0, 8'h55, 3));
        send_req(8'h10, 8'h01, 6'h20);
        for (int i = 0; i < 3; i++) serve_byte(1'b1, 1'b0);
        rx_data = 8'h11;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat (98) tick();
        rx_data = 8'hE0;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || resp_err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_edge: valid=%b tmo=%b want 0 0",
                     resp_valid, resp_err_timeout);
        end
        send_rx(8'h55);
        check_resp("timeout_edge");
    endtask

    task automatic test_backpressure();
        logic [12:0] exp;
        push_txn(8'h33, 8'h44, 6'h22);
        exp = model(8'h77, 8'h40, 8'h55, 3);
        resp_q.push_back(exp);
        send_req(8'h33, 8'h44, 6'h22);
        for (int i = 0; i < 3; i++) serve_byte(1'b1, 1'b0);
        send_rx(8'h77);
        send_rx(8'h40);
        send_rx(8'h55);
        wait_valid("bp_wait");
        for (int i = 0; i < 50; i++) begin
            req_valid = 1'b1;
            req_a = 8'($urandom);
            vectors++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                actual() !== exp) begin
                miscompares++;
                $display("FAIL bp_hold: valid=%b rdy=%b resp=%h want 1 0 %h",
                         resp_valid, req_ready, actual(), exp);
            end
            tick();
        end
        req_valid = 1'b0;
        check_resp("bp_release");
        repeat (5) begin
            tick();
            check_idle("bp_not_latched");
        end
    endtask

    task automatic test_rx_ignore();
        rx_data = 8'hEE;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        run_txn("rx_ignore", 8'h09, 8'h06, 6'h24, 8'h36, 8'h00, 8'h55, 1'b1);
    endtask

    task automatic test_reset_mid();
        push_txn(8'hA1, 8'hB2, 6'h3F);
        send_req(8'hA1, 8'hB2, 6'h3F);
        serve_byte(1'b1, 1'b0);
        serve_byte(1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("reset_wait_b");
        tx_q.delete();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        run_txn("after_rst_b", 8'h02, 8'h02, 6'h20, 8'h04, 8'h00, 8'h55, 1'b0);
        push_txn(8'hC3, 8'hD4, 6'h01);
        send_req(8'hC3, 8'hD4, 6'h01);
        for (int i = 0; i < 3; i++) serve_byte(1'b1, 1'b0);
        send_rx(8'h99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("reset_recv_flg");
        send_rx(8'hE1);
        run_txn("after_rst_f", 8'h0F, 8'hF0, 6'h30, 8'hFF, 8'h00, 8'h55, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, r, f;
        logic [5:0] op;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = 6'($urandom);
            r = 8'($urandom);
            f = 8'($urandom_range(0, 7)) << 5;
            run_txn("b2b", a, b, op, r, f, 8'h55, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_flags();
        test_bad_status();
        test_timeout();
        test_timeout_edge();
        test_backpressure();
        test_rx_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_alu_requester.md
Name: uart_alu_requester

Overview:
- Host-side initiator for the UART ALU protocol; runs on the FPGA and drives a remote (or looped-back) ALU peripheral.
- Accepts one request (A, B, op) on a valid/ready port and sends three bytes through a byte-level UART TX: A, B, then {2'b00, op}.
- Collects the three response bytes from a byte-level UART RX: result, flags {zero, overflow, carry, 5'b0}, status (0x55 = OK).
- Presents the decoded response on a valid/ready port, with status-error and timeout indications. Instantiated beside uart_tx/uart_rx and a shared baud generator.

Parameters:
- DATA_BITS, 8, operand/result width; must be 8.
- OK_STATUS, 8'h55, status byte value that means OK.
- TIMEOUT_CYCLES, 2_000_000, max clk cycles allowed between consecutive response bytes; must be >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  8  operand A
- req_b  in  8  operand B
- req_op  in  6  ALU opcode
- tx_start  out  1  one-cycle pulse to start a UART TX byte
- tx_data  out  8  byte to transmit
- tx_done  in  1  UART TX byte-complete tick
- rx_done  in  1  UART RX byte-valid tick
- rx_data  in  8  received byte, valid when rx_done=1
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_result  out  8  result byte
- resp_zero  out  1  flags[7]
- resp_overflow  out  1  flags[6]
- resp_carry  out  1  flags[5]
- resp_err_status  out  1  status byte != OK_STATUS, or flags[4:0] != 0
- resp_err_timeout  out  1  response byte timeout
- busy  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, req_ready=1, tx_start=0, tx_data=0, resp_valid=0, all resp_* fields=0, busy=0, timeout counter=0.
- State sequence: IDLE -> SEND_A -> WAIT_A -> SEND_B -> WAIT_B -> SEND_OP -> WAIT_OP -> RECV_RES -> RECV_FLG -> RECV_STA -> RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch A, B, op; clear result/flags/err registers; go to SEND_A.
  - req_ready falls on the next cycle and stays 0 until the block returns to IDLE.
- SEND_x (one cycle each):
  - tx_start=1 and tx_data = A / B / {2'b00, op} in that same cycle; next state is WAIT_x.
  - tx_data holds its value until the next SEND_x loads a new one.
- WAIT_x: tx_start=0; on tx_done advance to the next SEND state, or from WAIT_OP to RECV_RES.
- Any tx_done outside WAIT_x is ignored.
- Any rx_done outside RECV_* states is ignored (stray or echo bytes are discarded).
- RECV_RES / RECV_FLG / RECV_STA:
  - On rx_done capture rx_data into result / flags / status, then advance.
  - The timeout counter clears on entry to RECV_RES and on every rx_done.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no rx_done, go to RESP with err_timeout=1; fields not yet received stay 0.
  - If rx_done and expiry coincide, the byte wins and no timeout is flagged.
- RECV_STA capture: err_status = (rx_data != OK_STATUS) | (flags[4:0] != 0), registered together with the transition to RESP.
- RESP:
  - resp_valid=1; all resp_* fields are stable while resp_valid=1.
  - On resp_valid&resp_ready: resp_valid=0 next cycle and state returns to IDLE (req_ready=1 that same next cycle).
  - Minimum gap between consecutive requests is therefore 1 idle cycle.
- req_valid while busy has no effect; the request is not latched.
- Reset mid-operation (any state) returns the block to reset values on the next edge. tx_start is never left asserted.
- Timeout counter width is $clog2(TIMEOUT_CYCLES); the counter does not wrap.

Test Plan:
- Normal ADD: req A=0x05, B=0x03, op=0x20 -> tx bytes 0x05, 0x03, 0x20 in order, one tx_start pulse each, each pulse only after the previous tx_done; then rx 0x08, 0x00, 0x55 -> resp_valid=1, result=0x08, zero/overflow/carry=0, both errs=0.
- Flags decode: rx 0x00, 0xE0, 0x55 -> zero=overflow=carry=1, err_status=0. Repeat with flags=0xE1 -> err_status=1.
- Bad status: rx 0x3C, 0x00, 0xAA -> result=0x3C, err_status=1, err_timeout=0.
- Timeout (TIMEOUT_CYCLES=100): send completes, rx only 0x11, then silence -> resp_valid exactly 99 cycles after the 0x11 rx_done, result=0x11, flags=0, err_timeout=1. Variant: rx_done on the expiry cycle -> no timeout.
- Backpressure and ignore rules:
  - resp_ready held low for 50 cycles -> resp_valid and fields stable, req_ready=0, a second req_valid is not latched.
  - rx_done pulses injected during SEND/WAIT -> ignored; the response is still parsed correctly.
- Reset mid-operation: assert reset in WAIT_B, and again in RECV_FLG -> next cycle state=IDLE, req_ready=1, tx_start=0, resp_valid=0; a following full transaction completes correctly.
